// File: rtl/fetch_wide_pkg.sv
// Shared types and default parameters for the wide fetch unit.
// The packet layout is fixed here so the fetch unit, its buffer and the
// instruction queue downstream all agree on it.
package params;

  localparam int          DEF_FETCH_WIDTH = 2;
  localparam int          DEF_FBUF_DEPTH  = 8;
  localparam int          DEF_GHR_W       = 8;
  localparam logic [31:0] DEF_RESET_PC    = 32'h1eceb000;

  // One fetched instruction with the history seen when it was buffered.
  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [DEF_GHR_W-1:0] ghr;
  } fetch_pkt_t;

  // IDLE: no request out. WAIT: request live and wanted.
  // WAIT_STALE: request live but its answer must be dropped.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT       = 2'd1,
    ST_WAIT_STALE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_wide_fifo.sv
// Circular fetch buffer: accepts up to WR_W entries per cycle, hands out one
// per cycle, and can be emptied in a single cycle on a redirect.
module fetch_fifo
  import params::*;
#(
  parameter int DEPTH = DEF_FBUF_DEPTH,
  parameter int WR_W  = DEF_FETCH_WIDTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [CW-1:0]         wr_cnt,
  input  fetch_pkt_t [WR_W-1:0] wr_data,
  input  logic                  rd_en,
  output fetch_pkt_t            rd_data,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every block samples pre-edge values.
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(wr_cnt);
      if (rd_en) head <= head + AW'(1);
      count <= count + wr_cnt - CW'(rd_en);
    end
  end

  // Storage writes, entry j of the batch lands at tail+j.
  always_ff @(posedge clk) begin
    // NOTE: the array itself is not reset; head/tail/count decide validity.
    if (!rst && !flush) begin
      if (wr_cnt != '0) assert (wr_cnt <= CW'(DEPTH) - count);
      for (int j = 0; j < WR_W; j++) begin
        if (CW'(j) < wr_cnt) mem[tail + AW'(j)] <= wr_data[j];
      end
    end
  end

  assign rd_data = mem[head];
  assign empty   = (count == '0);

endmodule

// File: rtl/fetch_wide.sv
// Wide instruction fetch: requests one icache block at a time, buffers the
// usable slots with their PCs and drains them one per cycle into the
// instruction queue. Flush and decode redirects retarget fetch and empty the
// buffer; a request already in flight is answered and thrown away.
// Build option: define FETCH_GHR_EN to keep a global branch history register
// and tag each buffered packet with it; otherwise ghr is tied to zero.
module fetch_wide
  import params::*;
#(
  parameter int          FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int          FBUF_DEPTH  = DEF_FBUF_DEPTH,
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int          GHR_W       = DEF_GHR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              icache_ufp_addr,
  output logic                     icache_ufp_read,
  input  logic                     icache_ufp_resp,
  input  logic [32*FETCH_WIDTH-1:0] icache_ufp_rdata,
  output fetch_pkt_t               inst_q_wdata,
  output logic                     inst_q_enqueue,
  input  logic                     inst_q_full,
  input  logic                     flush,
  input  logic [31:0]              updated_pc,
  input  logic                     decode_pc_we,
  input  logic [31:0]              predicted_pc_next,
  input  logic                     branch_we,
  input  logic                     branch_taken,
  output logic [GHR_W-1:0]         ghr
);

  localparam int          AB        = $clog2(FETCH_WIDTH) + 2;
  localparam int          CW        = $clog2(FBUF_DEPTH) + 1;
  localparam logic [31:0] BLK_MASK  = 32'hffff_ffff << AB;
  localparam logic [31:0] BLK_BYTES = 32'(4 * FETCH_WIDTH);

  fetch_state_e state;
  fetch_state_e state_next;

  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic [31:0] blk_base;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        can_issue;
  logic        accept;
  int          slot_off;

  logic [CW-1:0]                fifo_count;
  logic [CW-1:0]                fifo_free;
  logic                         fifo_empty;
  logic [CW-1:0]                wr_cnt;
  fetch_pkt_t [FETCH_WIDTH-1:0] wr_data;

  // Slot index within the block for the j-th entry of a batch.
  function automatic int slot_of(input int off, input int j);
    return (off + j) % FETCH_WIDTH;
  endfunction

  // Flush wins over the decode redirect when both fire together.
  assign redirect        = flush | decode_pc_we;
  assign redirect_target = flush ? updated_pc : predicted_pc_next;

  assign blk_base  = fetch_pc & BLK_MASK;
  assign fifo_free = CW'(FBUF_DEPTH) - fifo_count;
  assign can_issue = (fifo_free >= CW'(FETCH_WIDTH)) && !redirect;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: any response ends the request; a redirect taints it.
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch.
    state_next = state;
    unique case (state)
      ST_IDLE:       if (can_issue)       state_next = ST_WAIT;
      ST_WAIT: begin
        if (icache_ufp_resp)              state_next = ST_IDLE;
        else if (redirect)                state_next = ST_WAIT_STALE;
      end
      ST_WAIT_STALE: if (icache_ufp_resp) state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: request strobe and how many slots a good response delivers.
  always_comb begin
    icache_ufp_read = (state != ST_IDLE) && !rst;
    slot_off        = int'((fetch_pc >> 2) & 32'(FETCH_WIDTH - 1));
    accept          = (state == ST_WAIT) && icache_ufp_resp && !redirect;
    wr_cnt          = '0;
    if (accept) wr_cnt = CW'(FETCH_WIDTH - slot_off);
  end

  // Build the batch in slot order starting at the fetch PC's slot.
  always_comb begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      wr_data[j].pc   = blk_base + 32'(4 * slot_of(slot_off, j));
      wr_data[j].inst = icache_ufp_rdata[32*slot_of(slot_off, j) +: 32];
      wr_data[j].ghr  = DEF_GHR_W'(ghr);
    end
  end

  // Fetch PC and latched request address; the address must not move while
  // the request is outstanding, even if fetch_pc is redirected meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC & BLK_MASK;
    end else begin
      if (redirect)    fetch_pc <= redirect_target;
      else if (accept) fetch_pc <= blk_base + BLK_BYTES;
      if (state == ST_IDLE && can_issue) req_addr <= blk_base;
    end
  end

  assign icache_ufp_addr = req_addr;
  assign inst_q_enqueue  = !fifo_empty && !inst_q_full && !flush &&
                           !decode_pc_we && !rst;

  fetch_fifo #(
    .DEPTH (FBUF_DEPTH),
    .WR_W  (FETCH_WIDTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (inst_q_enqueue),
    .rd_data (inst_q_wdata),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

`ifdef FETCH_GHR_EN
  logic [GHR_W-1:0] ghr_q;

  // Global history: shift in each resolved branch outcome.
  always_ff @(posedge clk) begin
    if (rst)            ghr_q <= '0;
    else if (branch_we) ghr_q <= {ghr_q[GHR_W-2:0], branch_taken};
  end

  assign ghr = ghr_q;
`else
  logic unused_branch;

  assign ghr           = '0;
  assign unused_branch = branch_we ^ branch_taken;
`endif

endmodule

// File: tb/tb_fetch_wide.sv
// Directed bench for fetch_wide at default parameters (2-wide, 8-deep).
module tb_fetch_wide;
  import params::*;

  localparam int FW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        icache_ufp_addr;
  logic               icache_ufp_read;
  logic               icache_ufp_resp = 1'b0;
  logic [32*FW-1:0]   icache_ufp_rdata = '0;
  fetch_pkt_t         inst_q_wdata;
  logic               inst_q_enqueue;
  logic               inst_q_full = 1'b0;
  logic               flush = 1'b0;
  logic [31:0]        updated_pc = '0;
  logic               decode_pc_we = 1'b0;
  logic [31:0]        predicted_pc_next = '0;
  logic               branch_we = 1'b0;
  logic               branch_taken = 1'b0;
  logic [7:0]         ghr;

  int errors = 0;
  int checks = 0;
  fetch_pkt_t got[$];

  fetch_wide dut (
    .clk               (clk),
    .rst               (rst),
    .icache_ufp_addr   (icache_ufp_addr),
    .icache_ufp_read   (icache_ufp_read),
    .icache_ufp_resp   (icache_ufp_resp),
    .icache_ufp_rdata  (icache_ufp_rdata),
    .inst_q_wdata      (inst_q_wdata),
    .inst_q_enqueue    (inst_q_enqueue),
    .inst_q_full       (inst_q_full),
    .flush             (flush),
    .updated_pc        (updated_pc),
    .decode_pc_we      (decode_pc_we),
    .predicted_pc_next (predicted_pc_next),
    .branch_we         (branch_we),
    .branch_taken      (branch_taken),
    .ghr               (ghr)
  );

  always #5 clk = ~clk;

  // Record every packet the DUT pushes, sampled mid-cycle.
  always @(negedge clk) if (inst_q_enqueue === 1'b1) got.push_back(inst_q_wdata);

  function automatic fetch_pkt_t got_at(input int i);
    if (i < got.size()) return got[i];
    return '0;
  endfunction

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (icache_ufp_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: request timeout, read=%b required 1", name, icache_ufp_read);
    end
  endtask

  task automatic respond(input logic [32*FW-1:0] data);
    cyc();
    icache_ufp_resp  = 1'b1;
    icache_ufp_rdata = data;
    cyc();
    icache_ufp_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (icache_ufp_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b required 0", icache_ufp_read); end
    checks++; if (inst_q_enqueue !== 1'b0) begin errors++; $display("FAIL rst_enq: got %b required 0", inst_q_enqueue); end
    checks++; if (ghr !== 8'h00) begin errors++; $display("FAIL rst_ghr: got %h required 00", ghr); end
    cyc();
    rst = 1'b0;
    got.delete();
    wait_req("first_req");
    checks++; if (icache_ufp_addr !== 32'h1eceb000) begin errors++; $display("FAIL first_addr: got %h required 1eceb000", icache_ufp_addr); end
  endtask

  task automatic test_basic();
    fetch_pkt_t p0, p1;
    got.delete();
    respond({32'hb0b0_0002, 32'ha0a0_0001});
    repeat (4) cyc();
    p0 = got_at(0);
    p1 = got_at(1);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL basic_cnt: got %0d required 2", got.size()); end
    checks++; if (p0.pc !== 32'h1eceb000) begin errors++; $display("FAIL basic_pc0: got %h required 1eceb000", p0.pc); end
    checks++; if (p0.inst !== 32'ha0a0_0001) begin errors++; $display("FAIL basic_inst0: got %h required a0a00001", p0.inst); end
    checks++; if (p0.ghr !== '0) begin errors++; $display("FAIL basic_ghr0: got %h required 00", p0.ghr); end
    checks++; if (p1.pc !== 32'h1eceb004) begin errors++; $display("FAIL basic_pc1: got %h required 1eceb004", p1.pc); end
    checks++; if (p1.inst !== 32'hb0b0_0002) begin errors++; $display("FAIL basic_inst1: got %h required b0b00002", p1.inst); end
    wait_req("basic_next");
    checks++; if (icache_ufp_addr !== 32'h1eceb008) begin errors++; $display("FAIL basic_next_addr: got %h required 1eceb008", icache_ufp_addr); end
  endtask

  task automatic test_misaligned();
    fetch_pkt_t p0;
    got.delete();
    cyc();
    decode_pc_we      = 1'b1;
    predicted_pc_next = 32'h1eceb00c;
    cyc();
    decode_pc_we      = 1'b0;
    respond({32'hdead_0002, 32'hdead_0001});
    wait_req("mis_req");
    checks++; if (icache_ufp_addr !== 32'h1eceb008) begin errors++; $display("FAIL mis_addr: got %h required 1eceb008", icache_ufp_addr); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL mis_stale_drop: got %0d entries required 0", got.size()); end
    respond({32'hb1b1_0002, 32'ha1a1_0001});
    repeat (4) cyc();
    p0 = got_at(0);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL mis_cnt: got %0d required 1", got.size()); end
    checks++; if (p0.pc !== 32'h1eceb00c) begin errors++; $display("FAIL mis_pc: got %h required 1eceb00c", p0.pc); end
    checks++; if (p0.inst !== 32'hb1b1_0002) begin errors++; $display("FAIL mis_inst: got %h required b1b10002", p0.inst); end
    wait_req("mis_next");
    checks++; if (icache_ufp_addr !== 32'h1eceb010) begin errors++; $display("FAIL mis_next_addr: got %h required 1eceb010", icache_ufp_addr); end
  endtask

  task automatic test_flush();
    fetch_pkt_t p0, p1;
    got.delete();
    cyc();
    inst_q_full = 1'b1;
    respond({32'hc0c0_0002, 32'hc0c0_0001});
    wait_req("flush_pre");
    cyc();
    flush      = 1'b1;
    updated_pc = 32'h1eceb100;
    cyc();
    flush      = 1'b0;
    respond({32'hdead_0004, 32'hdead_0003});
    inst_q_full = 1'b0;
    repeat (4) cyc();
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL flush_empty: got %0d entries required 0", got.size()); end
    wait_req("flush_req");
    checks++; if (icache_ufp_addr !== 32'h1eceb100) begin errors++; $display("FAIL flush_addr: got %h required 1eceb100", icache_ufp_addr); end
    respond({32'he0e0_0002, 32'he0e0_0001});
    repeat (4) cyc();
    p0 = got_at(0);
    p1 = got_at(1);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL flush_cnt: got %0d required 2", got.size()); end
    checks++; if (p0.pc !== 32'h1eceb100) begin errors++; $display("FAIL flush_pc0: got %h required 1eceb100", p0.pc); end
    checks++; if (p1.inst !== 32'he0e0_0002) begin errors++; $display("FAIL flush_inst1: got %h required e0e00002", p1.inst); end
  endtask

  task automatic test_full();
    fetch_pkt_t p;
    logic [31:0] pc;
    wait_req("full_pre");
    got.delete();
    cyc();
    inst_q_full = 1'b1;
    for (int i = 0; i < 12; i++) begin
      icache_ufp_resp  = icache_ufp_read;
      icache_ufp_rdata = {mk(icache_ufp_addr + 32'd4), mk(icache_ufp_addr)};
      cyc();
    end
    icache_ufp_resp = 1'b0;
    @(negedge clk);
    checks++; if (icache_ufp_read !== 1'b0) begin errors++; $display("FAIL full_stall: read=%b required 0", icache_ufp_read); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL full_hold: got %0d entries required 0", got.size()); end
    cyc();
    inst_q_full = 1'b0;
    repeat (12) cyc();
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL full_cnt: got %0d required 8", got.size()); end
    for (int k = 0; k < 8; k++) begin
      pc = 32'h1eceb108 + 32'(4 * k);
      p  = got_at(k);
      checks++; if (p.pc !== pc) begin errors++; $display("FAIL full_pc%0d: got %h required %h", k, p.pc, pc); end
      checks++; if (p.inst !== mk(pc)) begin errors++; $display("FAIL full_inst%0d: got %h required %h", k, p.inst, mk(pc)); end
    end
  endtask

  task automatic test_both_redirects();
    fetch_pkt_t p0;
    wait_req("both_pre");
    got.delete();
    cyc();
    flush             = 1'b1;
    updated_pc        = 32'h1eceb200;
    decode_pc_we      = 1'b1;
    predicted_pc_next = 32'h1eceb300;
    cyc();
    flush        = 1'b0;
    decode_pc_we = 1'b0;
    respond({32'hdead_0006, 32'hdead_0005});
    wait_req("both_req");
    checks++; if (icache_ufp_addr !== 32'h1eceb200) begin errors++; $display("FAIL both_addr: got %h required 1eceb200", icache_ufp_addr); end
    respond({32'h7070_0002, 32'h6060_0001});
    repeat (4) cyc();
    p0 = got_at(0);
    checks++; if (p0.pc !== 32'h1eceb200) begin errors++; $display("FAIL both_pc: got %h required 1eceb200", p0.pc); end
    checks++; if (p0.inst !== 32'h6060_0001) begin errors++; $display("FAIL both_inst: got %h required 60600001", p0.inst); end
  endtask

  task automatic test_ghr();
    logic [7:0] exp_ghr;
`ifdef FETCH_GHR_EN
    exp_ghr = 8'b0000_0101;
`else
    exp_ghr = 8'h00;
`endif
    cyc();
    branch_we    = 1'b1;
    branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    cyc();
    branch_taken = 1'b1;
    cyc();
    branch_we    = 1'b0;
    @(negedge clk);
    checks++; if (ghr !== exp_ghr) begin errors++; $display("FAIL ghr: got %b required %b", ghr, exp_ghr); end
  endtask

  task automatic test_reset_mid();
    wait_req("rmid_pre");
    got.delete();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (icache_ufp_read !== 1'b0) begin errors++; $display("FAIL rmid_read: got %b required 0", icache_ufp_read); end
    cyc();
    rst              = 1'b0;
    icache_ufp_resp  = 1'b1;
    icache_ufp_rdata = {32'hdead_0008, 32'hdead_0007};
    cyc();
    icache_ufp_resp  = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL rmid_ignored: got %0d entries required 0", got.size()); end
    checks++; if (icache_ufp_read !== 1'b1) begin errors++; $display("FAIL rmid_reissue: got %b required 1", icache_ufp_read); end
    checks++; if (icache_ufp_addr !== 32'h1eceb000) begin errors++; $display("FAIL rmid_addr: got %h required 1eceb000", icache_ufp_addr); end
    checks++; if (ghr !== 8'h00) begin errors++; $display("FAIL rmid_ghr: got %h required 00", ghr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_flush();
    test_full();
    test_both_redirects();
    test_ghr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_wide.md
FETCH_WIDE -- requirements
Module: fetch_wide

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2: instructions per icache block fetch (1, 2 or 4).
REQ-002 SHALL have parameter FBUF_DEPTH, default 8: fetch buffer entries, power of two, at least 2*FETCH_WIDTH.
REQ-003 SHALL have parameter RESET_PC, default 32'h1eceb000: first fetch address.
REQ-004 SHALL have parameter GHR_W, default 8: global history width.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- icache_ufp_addr  out  32  block-aligned request address.
- icache_ufp_read  out  1  request.
- icache_ufp_resp  in  1  response valid.
- icache_ufp_rdata  in  32*FETCH_WIDTH  slot i at bits [32i+31:32i].
- inst_q_wdata  out  fetch_pkt_t  {pc, inst, ghr}.
- inst_q_enqueue  out  1  push.
- inst_q_full  in  1  backpressure.
- flush  in  1  backend redirect.
- updated_pc  in  32  flush target.
- decode_pc_we  in  1  decode redirect.
- predicted_pc_next  in  32  decode target.
- branch_we  in  1  branch resolved.
- branch_taken  in  1  branch outcome.
- ghr  out  GHR_W  global history.

Function
REQ-006 SHALL keep a 3-state FSM: IDLE, WAIT, WAIT_STALE.
REQ-007 IDLE->WAIT SHALL occur when free buffer entries >= FETCH_WIDTH and no redirect is present this cycle.
REQ-008 In WAIT/WAIT_STALE, icache_ufp_read SHALL stay 1 and icache_ufp_addr SHALL stay stable until icache_ufp_resp.
REQ-009 Request address SHALL be fetch_pc with log2(FETCH_WIDTH)+2 LSBs cleared.
REQ-010 On resp in WAIT, the block SHALL write slots from fetch_pc slot offset through FETCH_WIDTH-1 into the buffer in ascending order.
REQ-011 After that write, fetch_pc SHALL become the next block base and the FSM SHALL go to IDLE.
REQ-012 A redirect in WAIT SHALL move the FSM to WAIT_STALE.
REQ-013 On resp in WAIT_STALE, the response SHALL be discarded, with no buffer write, and the FSM SHALL go to IDLE.
REQ-014 On a redirect, fetch_pc SHALL take the target and the buffer SHALL be emptied in the same cycle.
REQ-015 flush SHALL take priority over decode_pc_we when both are asserted.
REQ-016 A redirect coinciding with resp SHALL treat the response as stale.
REQ-017 The buffer SHALL be a circular FIFO with wrapping head/tail and a count of 0..FBUF_DEPTH.
REQ-018 The FIFO SHALL drain at most one entry per cycle: inst_q_enqueue = nonempty & ~inst_q_full & ~flush & ~decode_pc_we.
REQ-019 inst_q_wdata SHALL be the head entry, combinationally.
REQ-020 The FIFO SHALL allow a same-cycle resp write and drain; count changes by written minus drained.
REQ-021 The FIFO SHALL never overflow: REQ-007 guarantees space, and a write into a full buffer is an assertion failure.
REQ-022 Each entry pc SHALL equal block base + 4*slot.

Reset
REQ-023 On rst, the block SHALL set fetch_pc=RESET_PC, FSM=IDLE, FIFO empty, ghr=0.
REQ-024 On rst, icache_ufp_read=0 and inst_q_enqueue=0.
REQ-025 rst during WAIT SHALL abandon the request; a later resp in IDLE SHALL be ignored.

Configuration
REQ-026 Macro FETCH_GHR_EN defined: ghr SHALL shift left by one bit, inserting branch_taken, on branch_we, independent of redirects.
REQ-027 With FETCH_GHR_EN defined, each entry SHALL capture ghr at its buffer write.
REQ-028 Macro FETCH_GHR_EN undefined: the ghr output and the packet ghr field SHALL be constant 0, and branch_we/branch_taken SHALL be unused.

Structure
REQ-029 fetch_pkt_t, FETCH_WIDTH and GHR_W defaults SHALL live in package params.
REQ-030 The buffer SHALL be sub-module fetch_fifo, parameterised by depth, with a multi-write (up to FETCH_WIDTH), single-read, flush port.

Verification
REQ-031 Reset, FETCH_WIDTH=2: first addr=1eceb000; resp rdata {B,A} -> enqueues (1eceb000,A), then (1eceb004,B); next addr=1eceb008.
REQ-032 Misaligned redirect: decode_pc_we, predicted_pc_next=1eceb00c, WIDTH=2 -> request 1eceb008; only slot 1 is enqueued, with pc=1eceb00c.
REQ-033 flush=1 to 1eceb100 during WAIT -> next resp dropped, buffer empty, next request 1eceb100.
REQ-034 inst_q_full held 10 cycles with FBUF_DEPTH=8, WIDTH=2 -> read stops at count 7 or 8; no loss; order preserved after release.
REQ-035 flush and decode_pc_we in the same cycle -> fetch_pc=updated_pc.
REQ-036 FETCH_GHR_EN: branch_we with taken 1,0,1 -> ghr=8'b101; undefined -> ghr=0.
